// File: rtl/clefia_pkg.sv
// Shared constants and width helpers for the CLEFIA ciphertext serializer slice.
package clefia_pkg;

  localparam int BLOCK_W = 128;

  // Number of OUT_W-bit words per 128-bit block.
  function automatic int nbeats(input int out_w);
    return BLOCK_W / out_w;
  endfunction

  // Index width for a counter over n entries; never below one bit.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clefia_ct_serializer_if.sv
// Narrow valid/ready output stream carrying one block as NBEATS words.
interface clefia_ct_serializer_if #(
  parameter int OUT_W = 8
);
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/clefia_blk_fifo.sv
// DEPTH-entry FIFO of 128-bit blocks; head block is presented combinationally.
module clefia_blk_fifo
  import clefia_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [BLOCK_W-1:0] din,
  output logic [BLOCK_W-1:0] dout,
  output logic               full,
  output logic               empty
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [BLOCK_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;

  // NOTE: the block storage has no reset; count and the pointers decide which slots are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/clefia_ct_serializer.sv
// Captures each clefia_128 result on the rising edge of done and streams it MSW-first.
module clefia_ct_serializer
  import clefia_pkg::*;
#(
  parameter int OUT_W = 8,
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [BLOCK_W-1:0]            c,
  input  logic                          done,
  input  logic                          clr_ovf,
  output logic                          busy,
  output logic                          ovf,
  clefia_ct_serializer_if.master        stream
);
  localparam int NBEATS = nbeats(OUT_W);
  localparam int BW     = ptr_w(NBEATS);

  logic               done_q;
  logic               cap;
  logic               xfer;
  logic               pop;
  logic               push;
  logic               drop;
  logic               full;
  logic               empty;
  logic               last_beat;
  logic [BW-1:0]      beat;
  logic [BLOCK_W-1:0] head;
  logic [BLOCK_W-1:0] shifted;

  // done_q starts high so a done already asserted at reset release is ignored.
  always_ff @(posedge clk) begin
    if (reset) done_q <= 1'b1;
    else       done_q <= done;
  end

  assign cap       = done & ~done_q;
  assign last_beat = (beat == BW'(NBEATS - 1));
  assign xfer      = stream.out_valid & stream.out_ready;
  assign pop       = xfer & last_beat;
  // A full buffer still accepts when its head block leaves in the same cycle.
  assign push      = cap & (~full | pop);
  assign drop      = cap & full & ~pop;

  clefia_blk_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (c),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (reset)     beat <= '0;
    else if (xfer) beat <= last_beat ? '0 : beat + 1'b1;
  end

  // Set has priority over clear so a drop is never lost.
  always_ff @(posedge clk) begin
    if (reset)        ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (clr_ovf) ovf <= 1'b0;
  end

  always_comb begin
    shifted = head << (int'(beat) * OUT_W);
  end

  assign stream.out_valid = ~empty;
  assign stream.out_last  = stream.out_valid & last_beat;
  assign stream.out_data  = stream.out_valid ? shifted[BLOCK_W-1 -: OUT_W] : '0;
  assign busy             = ~empty;

endmodule
